// File: rtl/vector_sequencer.sv
// -----------------------------------------------------------------------------
// vector_sequencer
//   Stimulus/capture controller for a combinational ISCAS-style DUT. For each
//   vector index it reads a word from a synchronous vector memory and applies it
//   to the DUT through the registered dut_in. It then waits SETTLE_CYCLES
//   cycles, captures dut_out and offers the result on a valid/ready port.
//
//   Optional feature macro: VSEQ_MISR_EN
//     defined   : signature is a MISR folded over every captured response.
//     undefined : signature is tied to 0 and no MISR logic exists.
//
// Ports
//   clk, rst      rising-edge clock, asynchronous active-high reset
//   start         pulse to begin a run (ignored while busy)
//   num_tests     vector count, sampled when start is accepted
//   vec_rd_en     vector memory read strobe (FETCH cycle only)
//   vec_addr      vector memory address
//   vec_rd_data   vector memory read data (1-cycle latency)
//   dut_in        registered stimulus to the DUT
//   dut_out       combinational DUT response
//   res_valid     result handshake valid
//   res_ready     result handshake ready
//   res_data      captured DUT response
//   res_index     vector index of res_data
//   busy          run in progress
//   done          one-cycle end-of-run pulse
//   signature     MISR value (0 without VSEQ_MISR_EN)
// -----------------------------------------------------------------------------
module vector_sequencer #(
  parameter int                IN_W          = 50,
  parameter int                OUT_W         = 22,
  parameter int                ADDR_W        = 14,
  parameter int                SETTLE_CYCLES = 1,
  parameter logic [OUT_W-1:0]  MISR_POLY     = 22'h20_0003
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] num_tests,
  output logic              vec_rd_en,
  output logic [ADDR_W-1:0] vec_addr,
  input  logic [IN_W-1:0]   vec_rd_data,
  output logic [IN_W-1:0]   dut_in,
  input  logic [OUT_W-1:0]  dut_out,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [OUT_W-1:0]  res_data,
  output logic [ADDR_W-1:0] res_index,
  output logic              busy,
  output logic              done,
  output logic [OUT_W-1:0]  signature
);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_FETCH  = 3'd1;
  localparam logic [2:0] ST_LOAD   = 3'd2;
  localparam logic [2:0] ST_SETTLE = 3'd3;
  localparam logic [2:0] ST_EMIT   = 3'd4;
  localparam logic [2:0] ST_DONE   = 3'd5;

  localparam logic [7:0]        SETTLE_LAST = 8'(SETTLE_CYCLES - 1);
  localparam logic [ADDR_W-1:0] ADDR_ONE    = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] ADDR_ZERO   = {ADDR_W{1'b0}};

  logic [2:0]        state;
  logic [ADDR_W-1:0] index;
  logic [ADDR_W-1:0] num_tests_r;
  logic [7:0]        settle_cnt;
  logic              last_vec;
  logic              accept;
  logic              capture;

  // One shift/feedback step of the signature register.
  function automatic logic [OUT_W-1:0] misr_step(input logic [OUT_W-1:0] sig,
                                                 input logic [OUT_W-1:0] din);
    logic [OUT_W-1:0] fb;
    fb = sig[OUT_W-1] ? MISR_POLY : {OUT_W{1'b0}};
    misr_step = {sig[OUT_W-2:0], 1'b0} ^ fb ^ din;
  endfunction

  // Decode of the shared events used by the main FSM and the signature register.
  always_comb begin
    last_vec = (index == (num_tests_r - ADDR_ONE));
    accept   = (state == ST_IDLE) && start;
    capture  = (state == ST_SETTLE) && (settle_cnt == SETTLE_LAST);
  end

  // Main sequencing FSM; every output is a register updated here.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      index       <= ADDR_ZERO;
      num_tests_r <= ADDR_ZERO;
      settle_cnt  <= 8'd0;
      vec_rd_en   <= 1'b0;
      vec_addr    <= ADDR_ZERO;
      dut_in      <= {IN_W{1'b0}};
      res_valid   <= 1'b0;
      res_data    <= {OUT_W{1'b0}};
      res_index   <= ADDR_ZERO;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      // Strobes default low; they are raised only on the edge entering their state.
      vec_rd_en <= 1'b0;
      done      <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            num_tests_r <= num_tests;
            index       <= ADDR_ZERO;
            busy        <= 1'b1;
            if (num_tests == ADDR_ZERO) begin
              state <= ST_DONE;
              done  <= 1'b1;
            end else begin
              state     <= ST_FETCH;
              vec_rd_en <= 1'b1;
              vec_addr  <= ADDR_ZERO;
            end
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_FETCH: begin
          state <= ST_LOAD;
        end
        ST_LOAD: begin
          // Memory data arrives the cycle after the read strobe.
          dut_in     <= vec_rd_data;
          settle_cnt <= 8'd0;
          state      <= ST_SETTLE;
        end
        ST_SETTLE: begin
          if (capture) begin
            res_data  <= dut_out;
            res_index <= index;
            res_valid <= 1'b1;
            state     <= ST_EMIT;
          end else begin
            settle_cnt <= settle_cnt + 8'd1;
          end
        end
        ST_EMIT: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            if (last_vec) begin
              state <= ST_DONE;
              done  <= 1'b1;
            end else begin
              index     <= index + ADDR_ONE;
              vec_addr  <= index + ADDR_ONE;
              vec_rd_en <= 1'b1;
              state     <= ST_FETCH;
            end
          end else begin
            state <= ST_EMIT;
          end
        end
        ST_DONE: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: begin
          busy      <= 1'b0;
          res_valid <= 1'b0;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef VSEQ_MISR_EN
  logic [OUT_W-1:0] sig_r;

  // Signature: cleared on run start, folded with each captured response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sig_r <= {OUT_W{1'b0}};
    end else if (accept) begin
      sig_r <= {OUT_W{1'b0}};
    end else if (capture) begin
      sig_r <= misr_step(sig_r, dut_out);
    end else begin
      sig_r <= sig_r;
    end
  end

  assign signature = sig_r;
`else
  assign signature = {OUT_W{1'b0}};
`endif

endmodule

// File: tb/tb_vector_sequencer.sv
module tb_vector_sequencer;
  localparam int IN_W   = 50;
  localparam int OUT_W  = 22;
  localparam int ADDR_W = 14;

  typedef struct {
    logic [ADDR_W-1:0] idx;
    logic [OUT_W-1:0]  data;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Main instance (SETTLE_CYCLES = 1)
  logic              start;
  logic [ADDR_W-1:0] num_tests;
  logic              vec_rd_en;
  logic [ADDR_W-1:0] vec_addr;
  logic [IN_W-1:0]   vec_rd_data;
  logic [IN_W-1:0]   dut_in;
  logic [OUT_W-1:0]  dut_out;
  logic              res_valid;
  logic              res_ready;
  logic [OUT_W-1:0]  res_data;
  logic [ADDR_W-1:0] res_index;
  logic              busy;
  logic              done;
  logic [OUT_W-1:0]  signature;

  // Second instance (SETTLE_CYCLES = 5)
  logic              start5;
  logic [ADDR_W-1:0] num_tests5;
  logic              vec_rd_en5;
  logic [ADDR_W-1:0] vec_addr5;
  logic [IN_W-1:0]   vec_rd_data5;
  logic [IN_W-1:0]   dut_in5;
  logic [OUT_W-1:0]  dut_out5;
  logic              res_valid5;
  logic              res_ready5;
  logic [OUT_W-1:0]  res_data5;
  logic [ADDR_W-1:0] res_index5;
  logic              busy5;
  logic              done5;
  logic [OUT_W-1:0]  signature5;

  logic [IN_W-1:0] rom [0:63];
  exp_t sb[$];
  exp_t sb5[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   acc = 0;
  int   acc5 = 0;
  int   rd_cnt = 0;
  int   at;
  logic [OUT_W-1:0] model_sig = '0;
  logic [OUT_W-1:0] held;

  vector_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .num_tests(num_tests),
    .vec_rd_en(vec_rd_en), .vec_addr(vec_addr), .vec_rd_data(vec_rd_data),
    .dut_in(dut_in), .dut_out(dut_out), .res_valid(res_valid),
    .res_ready(res_ready), .res_data(res_data), .res_index(res_index),
    .busy(busy), .done(done), .signature(signature)
  );

  vector_sequencer #(.SETTLE_CYCLES(5)) dut5 (
    .clk(clk), .rst(rst), .start(start5), .num_tests(num_tests5),
    .vec_rd_en(vec_rd_en5), .vec_addr(vec_addr5), .vec_rd_data(vec_rd_data5),
    .dut_in(dut_in5), .dut_out(dut_out5), .res_valid(res_valid5),
    .res_ready(res_ready5), .res_data(res_data5), .res_index(res_index5),
    .busy(busy5), .done(done5), .signature(signature5)
  );

  // Vector memories with one-cycle read latency; the DUT model is a wire slice.
  always @(posedge clk) begin
    if (vec_rd_en)  vec_rd_data  <= rom[vec_addr[5:0]];
    if (vec_rd_en5) vec_rd_data5 <= rom[vec_addr5[5:0]];
    cyc <= cyc + 1;
  end
  assign dut_out  = dut_in[OUT_W-1:0];
  assign dut_out5 = dut_in5[OUT_W-1:0];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [OUT_W-1:0] misr_model(input logic [OUT_W-1:0] s,
                                                  input logic [OUT_W-1:0] d);
    logic [OUT_W-1:0] poly;
    poly = 22'h20_0003;
    return {s[OUT_W-2:0], 1'b0} ^ (s[OUT_W-1] ? poly : 22'h0) ^ d;
  endfunction

  // Scoreboard monitor for the main instance.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      sb.delete();
    end else begin
      if (vec_rd_en) rd_cnt++;
      if (res_valid && res_ready) begin
        if (sb.size() == 0) begin
          check("unexpected_result", 64'd1, 64'd0);
        end else begin
          e = sb.pop_front();
          check("res_data", 64'(res_data), 64'(e.data));
          check("res_index", 64'(res_index), 64'(e.idx));
`ifdef VSEQ_MISR_EN
          model_sig = misr_model(model_sig, e.data);
`endif
          check("signature", 64'(signature), 64'(model_sig));
        end
      end
    end
  end

  // Scoreboard monitor for the long-settle instance, including capture timing.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      sb5.delete();
    end else if (res_valid5 && res_ready5) begin
      if (sb5.size() == 0) begin
        check("s5_unexpected_result", 64'd1, 64'd0);
      end else begin
        e = sb5.pop_front();
        check("s5_res_data", 64'(res_data5), 64'(e.data));
        check("s5_res_index", 64'(res_index5), 64'(e.idx));
        check("s5_capture_cycle", 64'(cyc - acc5), 64'(7 + 8 * int'(e.idx)));
      end
    end
  end

  task automatic push_run(input int n, input bit to5);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      e.idx  = ADDR_W'(i);
      e.data = rom[i][OUT_W-1:0];
      if (to5) sb5.push_back(e);
      else     sb.push_back(e);
    end
  endtask

  task automatic go(input int n);
    @(posedge clk); #1;
    start = 1'b1; num_tests = ADDR_W'(n); model_sig = '0;
    @(posedge clk); #1;
    start = 1'b0; acc = cyc;
  endtask

  task automatic go5(input int n);
    @(posedge clk); #1;
    start5 = 1'b1; num_tests5 = ADDR_W'(n);
    @(posedge clk); #1;
    start5 = 1'b0; acc5 = cyc;
  endtask

  task automatic wait_done(input int limit, input bit on5, output int at_cyc);
    at_cyc = -1;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if ((!on5 && done) || (on5 && done5)) begin
        at_cyc = cyc;
        break;
      end
    end
    if (at_cyc < 0) check("done_timeout", 64'd0, 64'd1);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; num_tests = '0; res_ready = 1'b1;
    start5 = 1'b0; num_tests5 = '0; res_ready5 = 1'b1;
    for (int i = 0; i < 64; i++) rom[i] = IN_W'(i);
    repeat (3) @(posedge clk);
    #1;
    check("reset_flags", 64'({vec_rd_en, res_valid, busy, done}), 64'd0);
    check("reset_dut_in", 64'(dut_in), 64'd0);
    check("reset_res_data", 64'(res_data), 64'd0);
    check("reset_signature", 64'(signature), 64'd0);
    rst = 1'b0;

    // Basic run: ROM[i]=i, four vectors, ready tied high.
    push_run(4, 1'b0);
    go(4);
    wait_done(60, 1'b0, at);
    check("basic_done_latency", 64'(at - acc), 64'd16);
    check("dut_in_holds_last", 64'(dut_in), 64'(rom[3]));
    @(negedge clk);
    check("done_one_cycle", 64'({done, busy}), 64'd0);

    // Signature: responses 0x1 then 0x2.
    rom[0] = IN_W'(1); rom[1] = IN_W'(2);
    push_run(2, 1'b0);
    go(2);
    wait_done(60, 1'b0, at);
    check("misr_final", 64'(signature), 64'd0);

    for (int i = 0; i < 64; i++) rom[i] = {$urandom(), $urandom()};

    // Backpressure on vector 1.
    rd_cnt = 0;
    push_run(3, 1'b0);
    go(3);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (res_valid && res_index == '0) break;
    end
    @(posedge clk); #1;
    res_ready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (res_valid) break;
    end
    held = res_data;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_valid_held", 64'(res_valid), 64'd1);
      check("bp_data_held", 64'(res_data), 64'(held));
      check("bp_index_held", 64'(res_index), 64'd1);
      check("bp_no_fetch", 64'(vec_rd_en), 64'd0);
    end
    @(posedge clk); #1;
    res_ready = 1'b1;
    wait_done(60, 1'b0, at);
    check("bp_fetch_count", 64'(rd_cnt), 64'd3);

    // Zero-length run.
    rd_cnt = 0;
    go(0);
    wait_done(10, 1'b0, at);
    check("zero_done_latency", 64'(at - acc), 64'd0);
    check("zero_no_fetch", 64'(rd_cnt), 64'd0);

    // Start while busy is ignored; start in the DONE cycle is ignored.
    push_run(3, 1'b0);
    go(3);
    repeat (5) @(posedge clk);
    #1; start = 1'b1; num_tests = ADDR_W'(7);
    @(posedge clk); #1; start = 1'b0;
    wait_done(60, 1'b0, at);
    check("busy_start_ignored", 64'(at - acc), 64'd12);
    start = 1'b1; num_tests = ADDR_W'(5);
    @(posedge clk); #1; start = 1'b0;
    @(negedge clk);
    check("done_cycle_start_ignored", 64'(busy), 64'd0);
    check("sb_drained", 64'(sb.size()), 64'd0);

    // Reset mid-SETTLE of vector 3, then a fresh run from index 0.
    push_run(6, 1'b0);
    go(6);
    while (cyc < acc + 14) @(posedge clk);
    #1; rst = 1'b1;
    #1;
    check("midrun_reset_flags", 64'({vec_rd_en, res_valid, busy, done}), 64'd0);
    check("midrun_reset_dut_in", 64'(dut_in), 64'd0);
    check("midrun_reset_res", 64'({res_data, res_index, vec_addr}), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    sb.delete();
    @(negedge clk);
    check("no_done_after_reset", 64'(done), 64'd0);
    push_run(2, 1'b0);
    go(2);
    wait_done(40, 1'b0, at);
    check("after_reset_latency", 64'(at - acc), 64'd8);

    // Long settle instance: 8 cycles per vector.
    push_run(2, 1'b1);
    go5(2);
    wait_done(60, 1'b1, at);
    check("s5_done_latency", 64'(at - acc5), 64'd16);
    check("s5_sb_drained", 64'(sb5.size()), 64'd0);
    check("sb_final_drained", 64'(sb.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
